// File: rtl/ofm_drain_if.sv
// rtl/ofm_drain_if.sv - drained OFM word stream: valid/ready handshake with channel tag and last flag
interface ofm_drain_if #(
    parameter int DATA_W = 32,
    parameter int CH_W   = 2
);
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CH_W-1:0]   out_ch;
    logic              out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_ch,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_ch,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/ofm_drain.sv
// rtl/ofm_drain.sv - drains NUM_OFM output-feature-map memories, one address at a time, as a word stream
module ofm_drain #(
    parameter int NUM_OFM = 4,
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [ADDR_W-1:0]         base_addr,
    input  logic [ADDR_W:0]           word_count,
    input  logic [NUM_OFM*DATA_W-1:0] ofm_rdata,
    output logic [ADDR_W-1:0]         ofm_addr,
    output logic                      busy,
    output logic                      done,
    ofm_drain_if.master               out_if
);
    localparam int CH_W = (NUM_OFM > 1) ? $clog2(NUM_OFM) : 1;
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_OFM - 1);
    localparam logic [ADDR_W:0] REM_ONE = {{ADDR_W{1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        CAPT,
        SEND,
        DONE
    } state_t;

    state_t            state;
    logic [ADDR_W:0]   rem;
    logic [DATA_W-1:0] hold [NUM_OFM];
    logic [CH_W-1:0]   next_ch;

    assign next_ch = out_if.out_ch + 1'b1;

    // ofm_addr doubles as the current-address register; it stays put from ADDR through SEND.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            ofm_addr         <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            rem              <= '0;
            out_if.out_valid <= 1'b0;
            out_if.out_data  <= '0;
            out_if.out_ch    <= '0;
            out_if.out_last  <= 1'b0;
            for (int i = 0; i < NUM_OFM; i++) begin
                hold[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (word_count != '0) begin
                            ofm_addr <= base_addr;
                            rem      <= word_count;
                            state    <= ADDR;
                        end else begin
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                ADDR: state <= CAPT;
                CAPT: begin
                    for (int i = 0; i < NUM_OFM; i++) begin
                        hold[i] <= ofm_rdata[i*DATA_W +: DATA_W];
                    end
                    out_if.out_valid <= 1'b1;
                    out_if.out_data  <= ofm_rdata[DATA_W-1:0];
                    out_if.out_ch    <= '0;
                    out_if.out_last  <= (rem == REM_ONE) && (NUM_OFM == 1);
                    state            <= SEND;
                end
                SEND: begin
                    if (out_if.out_ready) begin
                        if (out_if.out_ch != LAST_CH) begin
                            out_if.out_data <= hold[next_ch];
                            out_if.out_ch   <= next_ch;
                            out_if.out_last <= (rem == REM_ONE) && (next_ch == LAST_CH);
                        end else begin
                            out_if.out_valid <= 1'b0;
                            out_if.out_last  <= 1'b0;
                            rem              <= rem - REM_ONE;
                            if (rem == REM_ONE) begin
                                done  <= 1'b1;
                                state <= DONE;
                            end else begin
                                ofm_addr <= ofm_addr + 1'b1;
                                state    <= ADDR;
                            end
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ofm_drain.sv
// tb/tb_ofm_drain.sv - scoreboard bench for ofm_drain against a memory-array reference model
module tb_ofm_drain;
    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [9:0]   base_addr;
    logic [10:0]  word_count;
    logic [127:0] ofm_rdata;
    logic [9:0]   ofm_addr;
    logic         busy;
    logic         done;

    ofm_drain_if #(.DATA_W(32), .CH_W(2)) oif ();

    ofm_drain #(.NUM_OFM(4), .ADDR_W(10), .DATA_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .ofm_rdata  (ofm_rdata),
        .ofm_addr   (ofm_addr),
        .busy       (busy),
        .done       (done),
        .out_if     (oif)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic [1:0]  c;
        logic        l;
    } exp_t;

    logic [31:0] mem [4][1024];
    exp_t        q[$];
    logic [9:0]  aq[$];
    int total = 0;
    int bad = 0;
    int popped = 0;
    int done_cnt = 0;
    int exp_done = 0;
    int valid_cycles = 0;
    int rmode = 0;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    always_ff @(posedge clk)
        ofm_rdata <= {mem[3][ofm_addr], mem[2][ofm_addr], mem[1][ofm_addr], mem[0][ofm_addr]};

    initial begin
        int ph = 0;
        oif.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                0: oif.out_ready = 1'b1;
                1: begin oif.out_ready = (ph % 3 == 0); ph++; end
                default: oif.out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: pops the scoreboard on every handshake and checks hold-stability under backpressure.
    logic        stall = 1'b0;
    logic [31:0] sd;
    logic [1:0]  sc;
    logic        sl;
    always @(negedge clk) begin
        if (rst) begin
            stall = 1'b0;
        end else begin
            if (done) done_cnt++;
            if (oif.out_valid) valid_cycles++;
            if (stall) begin
                chk("stall_valid", oif.out_valid, 1);
                chk("stall_data", oif.out_data, sd);
                chk("stall_ch", oif.out_ch, sc);
                chk("stall_last", oif.out_last, sl);
            end
            if (oif.out_valid && oif.out_ready) begin
                exp_t e;
                stall = 1'b0;
                chk("word_expected", q.size() > 0, 1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk("out_data", oif.out_data, e.d);
                    chk("out_ch", oif.out_ch, e.c);
                    chk("out_last", oif.out_last, e.l);
                    if (e.c == 2'd0) begin
                        chk("addr_expected", aq.size() > 0, 1);
                        if (aq.size() > 0) chk("ofm_addr", ofm_addr, aq.pop_front());
                    end
                end
                popped++;
            end else if (oif.out_valid) begin
                stall = 1'b1;
                sd = oif.out_data;
                sc = oif.out_ch;
                sl = oif.out_last;
            end else begin
                stall = 1'b0;
            end
        end
    end

    task automatic push_expect(input int base, input int cnt);
        for (int k = 0; k < cnt; k++) begin
            logic [9:0] a;
            a = 10'((base + k) % 1024);
            aq.push_back(a);
            for (int c = 0; c < 4; c++) begin
                exp_t e;
                e.d = mem[c][a];
                e.c = 2'(c);
                e.l = (k == cnt - 1) && (c == 3);
                q.push_back(e);
            end
        end
    endtask

    task automatic run_drain(input int base, input int cnt, input int mode, input bit spur);
        int n;
        int first_v;
        rmode = mode;
        @(posedge clk);
        #1;
        push_expect(base, cnt);
        exp_done++;
        start = 1'b1;
        base_addr = 10'(base);
        word_count = 11'(cnt);
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 1;
        first_v = 0;
        chk("busy_on_accept", busy, 1);
        while (!done && n < 20 * cnt + 50) begin
            if (spur && n == 4) begin
                start = 1'b1;
                base_addr = ~base_addr;
                word_count = 11'd5;
            end else begin
                start = 1'b0;
            end
            if (first_v == 0 && oif.out_valid) first_v = n;
            @(posedge clk);
            #1;
            n++;
        end
        start = 1'b0;
        chk("done_seen", done, 1);
        chk("busy_during_done", busy, 1);
        chk("valid_during_done", oif.out_valid, 0);
        if (mode == 0) begin
            chk("done_cycle", n, 6 * cnt + 1);
            if (cnt > 0) chk("first_valid_cycle", first_v, 3);
        end
        @(posedge clk);
        #1;
        chk("done_pulse_width", done, 0);
        chk("busy_after_done", busy, 0);
    endtask

    initial begin
        int n;
        int v0;
        int p0;
        for (int c = 0; c < 4; c++)
            for (int a = 0; a < 1024; a++)
                mem[c][a] = $urandom;
        rst = 1'b1;
        start = 1'b0;
        base_addr = '0;
        word_count = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ofm_addr", ofm_addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_valid", oif.out_valid, 0);
        chk("rst_data", oif.out_data, 0);
        chk("rst_ch", oif.out_ch, 0);
        chk("rst_last", oif.out_last, 0);
        chk("rst_done", done, 0);
        rst = 1'b0;

        run_drain(0, 1, 0, 1'b0);
        run_drain(5, 3, 0, 1'b0);
        run_drain(100, 2, 1, 1'b0);
        run_drain(1022, 4, 0, 1'b0);
        v0 = valid_cycles;
        run_drain(300, 0, 0, 1'b0);
        chk("count0_no_valid", valid_cycles, v0);
        run_drain(40, 3, 0, 1'b1);
        for (int i = 0; i < 12; i++)
            run_drain($urandom_range(0, 1023), $urandom_range(1, 5), $urandom_range(0, 2), 1'($urandom_range(0, 1)));

        // Abort in the middle of address 2 of 4, then confirm a fresh drain is clean.
        rmode = 0;
        @(posedge clk);
        #1;
        push_expect(700, 4);
        p0 = popped;
        start = 1'b1;
        base_addr = 10'd700;
        word_count = 11'd4;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 0;
        while (popped < p0 + 5 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("reached_addr2", popped >= p0 + 5, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_valid", oif.out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_data", oif.out_data, 0);
        chk("abort_ch", oif.out_ch, 0);
        chk("abort_last", oif.out_last, 0);
        chk("abort_addr", ofm_addr, 0);
        rst = 1'b0;
        q.delete();
        aq.delete();
        run_drain(900, 2, 0, 1'b0);

        run_drain($urandom_range(0, 1023), 1024, 0, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", q.size(), 0);
        chk("addr_queue_empty", aq.size(), 0);
        chk("done_pulse_count", done_cnt, exp_done);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
